ifetch: RTL
===========

# ifetch

Instruction fetch stage of the tinyriscv pipeline: owns the program counter, issues word fetches to instruction memory, buffers returned instructions in a small in-order FIFO and presents them, with their PC, to the decode stage through a valid/ready handshake. Redirects from execute (taken branches, jumps) flush all buffered and in-flight instructions and restart fetch at the new target. Decode consumes `inst` directly as its 32-bit instruction input.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `FIFO_DEPTH`, 4, instruction buffer entries; power of two, ≥2
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `imem_req`  out  1  fetch request, address valid
- `imem_addr`  out  32  word address of request, bits [1:0] always 00
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response data valid (in order, ≥1 cycle after grant)
- `imem_rdata`  in  32  response instruction word
- `redirect_valid`  in  1  flush and restart fetch
- `redirect_pc`  in  32  restart address
- `inst_valid`  out  1  instruction available to decode
- `inst`  out  32  instruction word
- `inst_pc`  out  32  PC of `inst`
- `inst_fault`  out  1  misaligned fetch target (see Configuration)
- `inst_ready`  in  1  decode accepts instruction this cycle

## Operation
- State: `pc` (next request address), `head_pc` (PC of FIFO head), FIFO of `FIFO_DEPTH` words, `count`, `outstanding` (granted, not yet returned), `discard` (responses to drop); counters are $clog2(FIFO_DEPTH)+1 bits.
- Issue: `imem_req` = (`count` + `outstanding` < `FIFO_DEPTH`), from registered state only; `imem_addr` = `pc`. On `imem_req && imem_gnt`: `pc` += 4, `outstanding` += 1. `imem_req` may drop without a grant.
- Response: on `imem_rvalid`, `outstanding` −= 1; if `discard` ≠ 0 then `discard` −= 1 and word dropped, else word pushed. Credit rule guarantees no overflow.
- Output: `inst_valid` = (`count` ≠ 0); `inst` = FIFO head; `inst_pc` = `head_pc`. Pop on `inst_valid && inst_ready`: `head_pc` += 4.
- Redirect (priority over pop, push, issue bookkeeping): FIFO emptied, `pc` and `head_pc` ← `redirect_pc` with bits [1:0] forced 00, `discard` ← `outstanding` after this cycle's grant/response updates (includes a same-cycle grant, excludes a same-cycle response, which is itself dropped), `inst_valid` low next cycle.
- Simultaneous push and pop: `count` unchanged. Push into empty FIFO visible next cycle.
- Arithmetic on `pc`/`head_pc` is modulo 2^32.

## Timing
- Reset (`rst_n` low at an edge): `pc`, `head_pc` = `RESET_PC`; `count`, `outstanding`, `discard` = 0. Outputs: `imem_req` 0 while `rst_n` low, `imem_addr` = `RESET_PC`, `inst_valid` 0, `inst` 0, `inst_pc` = `RESET_PC`, `inst_fault` 0.
- Reset mid-operation: in-flight responses arriving after reset are not dropped by the counter; the memory is reset with the core.
- First `imem_req` in the first cycle with `rst_n` high at the preceding edge.
- Latency: `imem_rvalid` in cycle N → `inst_valid` in N+1. Minimum grant-to-decode: memory latency + 1.
- Sustained 1 instruction/cycle when `FIFO_DEPTH` ≥ memory latency + 2 and `inst_ready` held high.
- Redirect in cycle R: first new request in R+1 at `redirect_pc`; first valid new instruction no earlier than R+1 + latency + 1.

## Configuration
- `IFETCH_MISALIGN_EN` defined: redirect with `redirect_pc[1:0]` ≠ 00 sets a fault flag; no requests issue, FIFO stays empty, output presents `inst_valid` 1, `inst_fault` 1, `inst` = 32'h0000_0013 (nop), `inst_pc` = unmasked `redirect_pc`; cleared only by a later redirect or reset (pop does not clear it).
- Undefined: `inst_fault` tied 0; low bits silently masked as above.

## Test plan
- Reset release, 1-cycle memory, `inst_ready` 1 → requests at 0x0, 0x4, 0x8…; `inst_pc` 0x0,0x4,0x8 back-to-back, first `inst_valid` 3 cycles after reset release.
- `inst_ready` 0 for 10 cycles → exactly `FIFO_DEPTH`=4 words buffered, `imem_req` low, no data lost; resume → in-order PCs 0x0..0xC.
- Redirect to 0x100 with 2 responses outstanding and same-cycle grant → 3 responses dropped, next `inst_pc` 0x100 with correct word.
- Random memory latency 1–3, random `inst_ready`, random redirects → decoded stream matches reference PC sequence, FIFO never overflows.
- `IFETCH_MISALIGN_EN`: redirect to 0x102 → `inst_valid` 1, `inst_fault` 1, `inst_pc` 0x102, no `imem_req`; redirect to 0x200 clears. Without macro: fetch at 0x100.

Source files
------------

// File: rtl/ifetch.sv
// tinyriscv instruction fetch stage; optional misaligned-target fault via IFETCH_MISALIGN_EN.

// Generic in-order FIFO with synchronous flush and occupancy count.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module ifetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Fetch stage: owns the PC, issues word fetches, buffers responses, hands them to decode.
// Latency: imem_rvalid in cycle N gives inst_valid in N+1; redirect restarts fetch the next cycle.
// Backpressure: inst_ready low fills the buffer, then imem_req drops once buffer + in-flight reach FIFO_DEPTH.
module ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        inst_ready
);
    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    logic [31:0]   pc;
    logic [31:0]   head_pc;
    logic [31:0]   head_dat;
    logic [31:0]   head_target;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] discard;
    logic [CW:0]   credit_used;
    logic          run_q;
    logic          fault;
    logic          target_misaligned;
    logic          grant;
    logic          drop;
    logic          push;
    logic          pop;

`ifdef IFETCH_MISALIGN_EN
    assign target_misaligned = |redirect_pc[1:0];

    // Sticky until the next redirect; pops never clear it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (redirect_valid) begin
            fault <= target_misaligned;
        end
    end
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign target_misaligned   = 1'b0;
    assign fault               = 1'b0;
`endif

    always_comb begin
        credit_used     = {1'b0, count} + {1'b0, outstanding};
        // rst_n gates the request combinationally; run_q holds it off for the release cycle.
        imem_req        = rst_n && run_q && !fault && (credit_used < DEPTH_W);
        imem_addr       = pc;
        grant           = imem_req && imem_gnt;
        outstanding_nxt = outstanding + CW'(grant) - CW'(imem_rvalid);
        drop            = imem_rvalid && (discard != '0);
        push            = imem_rvalid && !drop && !redirect_valid;
        pop             = (count != '0) && inst_ready && !redirect_valid;
        head_target     = target_misaligned ? redirect_pc : {redirect_pc[31:2], 2'b00};
        inst_valid      = fault || (count != '0);
        inst            = fault ? NOP : head_dat;
        inst_pc         = head_pc;
        inst_fault      = fault;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            head_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            run_q       <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                pc      <= {redirect_pc[31:2], 2'b00};
                head_pc <= head_target;
                discard <= outstanding_nxt;
            end else begin
                if (grant) begin
                    pc <= pc + 32'd4;
                end
                if (pop) begin
                    head_pc <= head_pc + 32'd4;
                end
                if (drop) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    ifetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat (imem_rdata),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .count    (count)
    );
endmodule
